// File: rtl/axi_mst_pkg.sv
// Shared types and constants for the AXI4-Lite single-transaction master.
package axi_mst_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  localparam logic [DATA_W-1:0] TIMEOUT_PATTERN = 32'hDEAD_DEAD;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one cmd into one AXI read or write, returns one rsp.
// Optional watchdog abort compiled in with `define AXI_MST_TIMEOUT_EN.
module axi_lite_master
  import axi_mst_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [RESP_W-1:0] rsp_resp,

  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,

  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,

  input  logic [RESP_W-1:0] m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,

  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,

  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [RESP_W-1:0] m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [RESP_W-1:0]   rsp_resp_q, rsp_resp_d;

`ifdef AXI_MST_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

  // State and all output-facing registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXI_MST_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_MST_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXI_MST_TIMEOUT_EN
    cnt_d       = cnt_q;
    busy        = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
`ifdef AXI_MST_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (cmd_wr) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // Address and data channels complete independently, in any order.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXI_MST_TIMEOUT_EN
    // Watchdog: a transaction finishing on the expiry cycle still wins.
    busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
           (state_q == RD_REQ) || (state_q == RD_DATA);
    if (busy) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
      if ((cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && (state_d != RSP)) begin
        state_d     = RSP;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = TIMEOUT_PATTERN;
        rsp_resp_d  = RESP_SLVERR;
      end
    end
`endif
  end

  assign cmd_ready     = reset_n && (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = {STRB_W{1'b1}};
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-configurable slave plus a latency/payload model.
module tb_axi_lite_master;

  localparam int unsigned TO = 16;

  logic        clk, reset_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axi_lite_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Slave config: cycles a valid (or ready) must be high before the slave answers; 0 = never.
  int cfg_aw = 1, cfg_w = 1, cfg_ar = 1, cfg_b = 1, cfg_r = 1;
  int aw_run, w_run, ar_run, b_run, r_run;
  int aw_hi, w_hi, ar_hi;
  int hs_aw, hs_w, hs_ar, hs_b, hs_r;
  logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
  logic [3:0]  seen_wstrb;

  // Slave responds at the falling edge from what it sees of the master.
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_rvalid = 0;
    aw_run = 0; w_run = 0; ar_run = 0; b_run = 0; r_run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        aw_run = 0; w_run = 0; ar_run = 0; b_run = 0; r_run = 0;
      end else begin
        if (m_axi_awvalid) begin
          aw_run++; aw_hi++;
          m_axi_awready = (aw_run >= cfg_aw);
          if (m_axi_awready) begin hs_aw++; seen_awaddr = m_axi_awaddr; end
        end else begin aw_run = 0; m_axi_awready = 0; end
        if (m_axi_wvalid) begin
          w_run++; w_hi++;
          m_axi_wready = (w_run >= cfg_w);
          if (m_axi_wready) begin hs_w++; seen_wdata = m_axi_wdata; seen_wstrb = m_axi_wstrb; end
        end else begin w_run = 0; m_axi_wready = 0; end
        if (m_axi_arvalid) begin
          ar_run++; ar_hi++;
          m_axi_arready = (ar_run >= cfg_ar);
          if (m_axi_arready) begin hs_ar++; seen_araddr = m_axi_araddr; end
        end else begin ar_run = 0; m_axi_arready = 0; end
        if (m_axi_bready) begin
          b_run++;
          m_axi_bvalid = (cfg_b != 0) && (b_run >= cfg_b);
          if (m_axi_bvalid) hs_b++;
        end else begin b_run = 0; m_axi_bvalid = 0; end
        if (m_axi_rready) begin
          r_run++;
          m_axi_rvalid = (cfg_r != 0) && (r_run >= cfg_r);
          if (m_axi_rvalid) hs_r++;
        end else begin r_run = 0; m_axi_rvalid = 0; end
      end
    end
  end

  // Issue one command; returns with cmd_valid low just after the accepting edge.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int budget;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
    budget = 0;
    while (!cmd_ready && budget < 50) begin @(negedge clk); budget++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    aw_hi = 0; w_hi = 0; ar_hi = 0;
    hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
    seen_awaddr = 0; seen_wdata = 0; seen_araddr = 0; seen_wstrb = 0;
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int daw, input int dw, input int dar, input int db, input int dr,
                        input logic [1:0] sresp, input logic [31:0] srdata, input int hold);
    int busy, exp_lat, lat;
    bit exp_to, stable;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    // Model: one cycle to accept, busy cycles for request+response, then RSP.
    busy = wr ? (((daw > dw) ? daw : dw) + ((db == 0) ? 1000 : db))
              : (dar + ((dr == 0) ? 1000 : dr));
    exp_to = 1'b0;
`ifdef AXI_MST_TIMEOUT_EN
    if (busy > int'(TO)) exp_to = 1'b1;
`endif
    exp_lat   = exp_to ? 1 + int'(TO) : 1 + busy;
    exp_rdata = exp_to ? 32'hDEADDEAD : (wr ? 32'h0 : srdata);
    exp_resp  = exp_to ? 2'b10 : sresp;

    @(negedge clk);
    cfg_aw = daw; cfg_w = dw; cfg_ar = dar; cfg_b = db; cfg_r = dr;
    m_axi_bresp = sresp; m_axi_rresp = sresp; m_axi_rdata = srdata;
    issue(wr, addr, wdata);

    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 100);
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    if (!rsp_valid) return;
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
    check("cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);

    if (wr) begin
      check("awaddr", seen_awaddr, addr);
      check("wdata", seen_wdata, wdata);
      check("wstrb", 32'(seen_wstrb), 32'hF);
      check("awvalid_cycles", 32'(aw_hi), 32'(daw));
      check("wvalid_cycles", 32'(w_hi), 32'(dw));
      check("aw_handshakes", 32'(hs_aw), 32'd1);
      check("b_handshakes", 32'(hs_b), exp_to ? 32'd0 : 32'd1);
      check("bready_in_rsp", 32'(m_axi_bready), 32'd0);
    end else begin
      check("araddr", seen_araddr, addr);
      check("arvalid_cycles", 32'(ar_hi), 32'(dar));
      check("r_handshakes", 32'(hs_r), exp_to ? 32'd0 : 32'd1);
      check("rready_in_rsp", 32'(m_axi_rready), 32'd0);
    end

    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      stable &= rsp_valid && (rsp_rdata === exp_rdata) && (rsp_resp === exp_resp) && !cmd_ready;
    end
    check("rsp_hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_ack", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after_ack", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got stuck expected completion");
    $fatal(1);
  end

  initial begin
    int budget;
    cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    reset_n = 0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'd0);
    check("reset_readies", 32'({m_axi_bready, m_axi_rready}), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_resp", 32'(rsp_resp), 32'd0);
    check("reset_addr", m_axi_awaddr, 32'd0);
    reset_n = 1;
    #1 check("release_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write, delayed-arready read, w-before-aw write, long rsp backpressure.
    do_txn(1, 32'h1, 32'h12345678, 1, 1, 1, 1, 1, 2'b00, 32'h0, 0);
    do_txn(0, 32'h1001, 32'h0, 1, 1, 5, 1, 1, 2'b00, 32'hCAFEF00D, 0);
    do_txn(1, 32'h2004, 32'hA5A5_0F0F, 4, 1, 1, 1, 1, 2'b00, 32'h0, 0);
    do_txn(0, 32'h3008, 32'h0, 1, 1, 2, 3, 1, 2'b10, 32'h0BAD_BEEF, 10);

    // Reset while waiting for read data.
    @(negedge clk);
    cfg_ar = 1; cfg_r = 0;
    issue(0, 32'h4000, 32'h0);
    budget = 0;
    while (!m_axi_rready && budget < 20) begin @(negedge clk); budget++; end
    check("mid_rd_rready_seen", 32'(m_axi_rready), 32'd1);
    reset_n = 0;
    #1;
    check("midrst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("midrst_rready", 32'(m_axi_rready), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst_araddr", m_axi_araddr, 32'd0);
    @(negedge clk);
    reset_n = 1;
    #1 check("midrst_release_cmd_ready", 32'(cmd_ready), 32'd1);
    do_txn(0, 32'h5010, 32'h0, 1, 1, 2, 1, 2, 2'b00, 32'h1357_9BDF, 1);

`ifdef AXI_MST_TIMEOUT_EN
    do_txn(1, 32'h6000, 32'h1111_2222, 1, 1, 1, 0, 1, 2'b00, 32'h0, 2);
    do_txn(0, 32'h6100, 32'h0, 1, 1, 3, 0, 0, 2'b00, 32'h0, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      do_txn(1'($urandom_range(1, 0)), $urandom, $urandom,
             int'($urandom_range(4, 1)), int'($urandom_range(4, 1)), int'($urandom_range(5, 1)),
             int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
             2'($urandom_range(3, 0)), $urandom, int'($urandom_range(3, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
